nes6502_core: RTL and testbench
===============================

Name: nes6502_core

Overview:
- Subset 6502-compatible CPU core (NES 2A03 style, no decimal mode), read-only memory interface.
- Fetches opcodes/operands over a 16-bit address / 8-bit data bus; executes load-immediate, register transfer/inc/dec, carry set/clear, and ADC/SBC/CMP/CPX/CPY.
- Exposes architectural registers and the instruction cycle counter for debug.
- Sits as the processor in the NES top level; memory is combinational (data valid in the same cycle as the address).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk_ph1  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Data_bus  in  8  read data for the current Addr_bus, sampled at the rising edge.
- Addr_bus  out  16  memory address, combinational from current state.
- IR_dbg  out  8  instruction register.
- AC_dbg  out  8  accumulator A.
- X_dbg  out  8  index X.
- Y_dbg  out  8  index Y.
- P_dbg  out  8  status {N,V,1,B=0,D=0,I=0,Z,C}.
- PC_dbg  out  16  program counter.
- cycle_dbg  out  3  cycle within current instruction, 0 = opcode fetch.

Behaviour:
- Reset (rst=1 at an edge, any cycle, including mid-instruction):
  - PC=RESET_PC; A=X=Y=IR=0; P=8'h20; cycle=0.
  - Addr_bus=PC while in reset.
  - First fetch occurs in the cycle after rst is released.
- Cycle 0: Addr_bus=PC; IR<=Data_bus; PC++.
- Operand fetches (immediate, address bytes, pointer): Addr_bus=PC, PC++.
- Execute completes at the edge ending the last cycle; the next cycle is cycle 0. No fetch/execute overlap.
- Cycle timing (cycles after cycle 0, addresses per cycle):
  - Implied (CLC, SEC, transfers, INC/DEC): c1 dummy read at PC (no increment), execute. 2 total.
  - Immediate: c1 read operand at PC, execute. 2 total.
  - Zero page: c1 ADL; c2 read {00,ADL}. 3 total.
  - Absolute: c1 ADL; c2 ADH; c3 read {ADH,ADL}. 4 total.
  - Zero page,X: c1 ADL; c2 dummy {00,ADL}; c3 read {00,(ADL+X)&FF}. 4 total.
  - Absolute,X/Y: c1 ADL; c2 ADH; c3 read {ADH,(ADL+idx)&FF}. No carry out of the low byte: execute (4 total). Carry: c4 reads the correct address {ADH+1,...} (5 total).
  - (Indirect,X): c1 ptr; c2 dummy {00,ptr}; c3 low {00,ptr+X}; c4 high {00,ptr+X+1}; c5 read operand. 6 total. All pointer math wraps in zero page.
  - (Indirect),Y: c1 ptr; c2 low {00,ptr}; c3 high {00,ptr+1}; c4 read {H,(L+Y)&FF}; page cross adds c5 (5 or 6 total).
- Opcodes:
  - ADC 69/65/75/6D/7D/79/61/71; SBC E9/E5/F5/ED/FD/F9/E1/F1.
  - CMP C9/C5/D5/CD/DD/D9/C1/D1; CPX E0/E4/EC; CPY C0/C4/CC.
  - LDA A9, LDX A2, LDY A0.
  - SEC 38, CLC 18.
  - INX E8, INY C8, DEX CA, DEY 88.
  - TAX AA, TXA 8A, TAY A8, TYA 98.
- Arithmetic and flags:
  - ADC: R=A+M+C (9-bit). C=bit8; V=(A^R)&(M^R)&80h ≠0; N=R[7]; Z=(R[7:0]==0); A<=R.
  - SBC: identical to ADC with M replaced by ~M. D flag is ignored; always binary.
  - CMP/CPX/CPY: R=reg−M. C=(reg>=M unsigned); Z=(reg==M); N=R[7]; V unchanged; register unchanged.
  - Loads, transfers, INC/DEC: set N,Z from the result; INC/DEC wrap mod 256 (FF+1=00, 00−1=FF).
  - SEC/CLC: C only.
- Unsupported opcodes: execute as 2-cycle implied NOP; no register/flag change.
- PC wraps FFFF→0000.
- Debug outputs reflect registered state, updated at the same edge as the architectural state.

Test Plan:
- rst=1 for 2 edges, then release; program at 0: A9 00 A2 0A A0 10 8A 18 69 10.
  - Expect A=00 (Z=1); X=0A; Y=10; after TXA A=0A; after ADC A=1A, P=20 (C=0,V=0).
  - PC=000A after 14 cycles.
- Flag cases:
  - LDA #7F; CLC; ADC #01 → A=80, N=1, V=1, C=0.
  - LDA #FF; SEC; ADC #00 → A=00, Z=1, C=1.
- SEC; LDA #05; SBC #06 → A=FF, N=1, C=0, V=0. LDA #10; CMP #10 → Z=1, C=1, A=10.
- LDX #FF; INX → X=00, Z=1. DEY from 00 → Y=FF, N=1.
- Absolute,X timing:
  - ADC $12F0,X with X=0F → 4 cycles, read 12FF.
  - X=10 → 5 cycles, dummy read 1200, then read 1300.
- Assert rst during cycle 3 of an (ind),Y instruction → next cycle PC=0000, cycle_dbg=0, A=X=Y=0, P=20.

Source files
------------

// File: rtl/nes6502_core.sv
// Subset 6502 core (2A03 flavour, binary only): multi-cycle fetch/execute over a
// combinational read-only bus, with architectural state exposed for debug.
module nes6502_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [7:0]  Data_bus,
  output logic [15:0] Addr_bus,
  output logic [7:0]  IR_dbg,
  output logic [7:0]  AC_dbg,
  output logic [7:0]  X_dbg,
  output logic [7:0]  Y_dbg,
  output logic [7:0]  P_dbg,
  output logic [15:0] PC_dbg,
  output logic [2:0]  cycle_dbg
);

  typedef enum logic [2:0] {C0, C1, C2, C3, C4, C5} cyc_t;
  typedef enum logic [3:0] {AM_IMP, AM_IMM, AM_ZP, AM_ZPX, AM_ABS, AM_ABX, AM_ABY,
                            AM_INX, AM_INY} amode_t;
  typedef enum logic [4:0] {OP_NOP, OP_ADC, OP_SBC, OP_CMP, OP_CPX, OP_CPY, OP_LDA,
                            OP_LDX, OP_LDY, OP_SEC, OP_CLC, OP_INX, OP_INY, OP_DEX,
                            OP_DEY, OP_TAX, OP_TXA, OP_TAY, OP_TYA} op_t;

  cyc_t        cyc, cyc_nx;
  amode_t      am;
  op_t         op;
  logic        last;
  logic [15:0] pc;
  logic [7:0]  ir, a, x, y, eal, eah, ptr, idx;
  logic        fn, fv, fz, fc;
  logic [8:0]  idx_sum, sum, diff;
  logic [7:0]  m_op, cmp_reg, res;
  logic [7:0]  a_nx, x_nx, y_nx;
  logic        fn_nx, fv_nx, fz_nx, fc_nx, set_nz;

  // ALU group aaa_bbb_01 covers every ADC/SBC/CMP addressing mode.
  always_comb begin
    am = AM_IMP;
    op = OP_NOP;
    if (ir[1:0] == 2'b01 && (ir[7:5] == 3'b011 || ir[7:5] == 3'b110 || ir[7:5] == 3'b111)) begin
      case (ir[7:5])
        3'b011:  op = OP_ADC;
        3'b111:  op = OP_SBC;
        default: op = OP_CMP;
      endcase
      case (ir[4:2])
        3'd0:    am = AM_INX;
        3'd1:    am = AM_ZP;
        3'd2:    am = AM_IMM;
        3'd3:    am = AM_ABS;
        3'd4:    am = AM_INY;
        3'd5:    am = AM_ZPX;
        3'd6:    am = AM_ABY;
        default: am = AM_ABX;
      endcase
    end else begin
      case (ir)
        8'hE0: begin op = OP_CPX; am = AM_IMM; end
        8'hE4: begin op = OP_CPX; am = AM_ZP;  end
        8'hEC: begin op = OP_CPX; am = AM_ABS; end
        8'hC0: begin op = OP_CPY; am = AM_IMM; end
        8'hC4: begin op = OP_CPY; am = AM_ZP;  end
        8'hCC: begin op = OP_CPY; am = AM_ABS; end
        8'hA9: begin op = OP_LDA; am = AM_IMM; end
        8'hA2: begin op = OP_LDX; am = AM_IMM; end
        8'hA0: begin op = OP_LDY; am = AM_IMM; end
        8'h38: op = OP_SEC;
        8'h18: op = OP_CLC;
        8'hE8: op = OP_INX;
        8'hC8: op = OP_INY;
        8'hCA: op = OP_DEX;
        8'h88: op = OP_DEY;
        8'hAA: op = OP_TAX;
        8'h8A: op = OP_TXA;
        8'hA8: op = OP_TAY;
        8'h98: op = OP_TYA;
        default: ;
      endcase
    end
  end

  assign idx     = (am == AM_ABX) ? x : y;
  assign idx_sum = {1'b0, eal} + {1'b0, idx};

  always_ff @(posedge clk_ph1) begin
    if (rst) cyc <= C0;
    else     cyc <= cyc_nx;
  end

  // Indexed modes finish one cycle early when the low-byte add does not carry.
  always_comb begin
    case (am)
      AM_ZP:          last = (cyc == C2);
      AM_ZPX, AM_ABS: last = (cyc == C3);
      AM_ABX, AM_ABY: last = (cyc == C4) || (cyc == C3 && !idx_sum[8]);
      AM_INX:         last = (cyc == C5);
      AM_INY:         last = (cyc == C5) || (cyc == C4 && !idx_sum[8]);
      default:        last = (cyc == C1);
    endcase
    cyc_nx = last ? C0 : cyc_t'(cyc + 3'd1);
  end

  always_comb begin
    Addr_bus = pc;
    case (cyc)
      C2: begin
        if (am == AM_ZP || am == AM_ZPX)       Addr_bus = {8'h00, eal};
        else if (am == AM_INX || am == AM_INY) Addr_bus = {8'h00, ptr};
      end
      C3: begin
        case (am)
          AM_ABS:         Addr_bus = {eah, eal};
          AM_ABX, AM_ABY: Addr_bus = {eah, idx_sum[7:0]};
          AM_ZPX:         Addr_bus = {8'h00, eal + x};
          AM_INX:         Addr_bus = {8'h00, ptr + x};
          AM_INY:         Addr_bus = {8'h00, ptr + 8'd1};
          default: ;
        endcase
      end
      C4: begin
        case (am)
          AM_ABX, AM_ABY: Addr_bus = {eah + 8'd1, idx_sum[7:0]};
          AM_INX:         Addr_bus = {8'h00, ptr + x + 8'd1};
          AM_INY:         Addr_bus = {eah, idx_sum[7:0]};
          default: ;
        endcase
      end
      C5: begin
        if (am == AM_INX)      Addr_bus = {eah, eal};
        else if (am == AM_INY) Addr_bus = {eah + 8'd1, idx_sum[7:0]};
      end
      default: ;
    endcase
  end

  // SBC reuses the ADC adder on the inverted operand.
  assign m_op    = (op == OP_SBC) ? ~Data_bus : Data_bus;
  assign sum     = {1'b0, a} + {1'b0, m_op} + {8'h00, fc};
  assign cmp_reg = (op == OP_CPX) ? x : (op == OP_CPY) ? y : a;
  assign diff    = {1'b0, cmp_reg} - {1'b0, Data_bus};

  always_comb begin
    a_nx = a; x_nx = x; y_nx = y;
    fn_nx = fn; fv_nx = fv; fz_nx = fz; fc_nx = fc;
    res = 8'h00;
    set_nz = 1'b0;
    case (op)
      OP_ADC, OP_SBC: begin
        a_nx = sum[7:0]; fc_nx = sum[8];
        fv_nx = ((a ^ sum[7:0]) & (m_op ^ sum[7:0]) & 8'h80) != 8'h00;
        res = sum[7:0]; set_nz = 1'b1;
      end
      OP_CMP, OP_CPX, OP_CPY: begin fc_nx = ~diff[8]; res = diff[7:0]; set_nz = 1'b1; end
      OP_LDA: begin a_nx = Data_bus; res = Data_bus; set_nz = 1'b1; end
      OP_LDX: begin x_nx = Data_bus; res = Data_bus; set_nz = 1'b1; end
      OP_LDY: begin y_nx = Data_bus; res = Data_bus; set_nz = 1'b1; end
      OP_SEC: fc_nx = 1'b1;
      OP_CLC: fc_nx = 1'b0;
      OP_INX: begin x_nx = x + 8'd1; res = x_nx; set_nz = 1'b1; end
      OP_INY: begin y_nx = y + 8'd1; res = y_nx; set_nz = 1'b1; end
      OP_DEX: begin x_nx = x - 8'd1; res = x_nx; set_nz = 1'b1; end
      OP_DEY: begin y_nx = y - 8'd1; res = y_nx; set_nz = 1'b1; end
      OP_TAX: begin x_nx = a; res = a; set_nz = 1'b1; end
      OP_TXA: begin a_nx = x; res = x; set_nz = 1'b1; end
      OP_TAY: begin y_nx = a; res = a; set_nz = 1'b1; end
      OP_TYA: begin a_nx = y; res = y; set_nz = 1'b1; end
      default: ;
    endcase
    if (set_nz) begin
      fn_nx = res[7];
      fz_nx = (res == 8'h00);
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0; a <= '0; x <= '0; y <= '0;
      eal <= '0; eah <= '0; ptr <= '0;
      fn <= 1'b0; fv <= 1'b0; fz <= 1'b0; fc <= 1'b0;
    end else begin
      case (cyc)
        C0: begin ir <= Data_bus; pc <= pc + 16'd1; end
        C1: if (am != AM_IMP) begin pc <= pc + 16'd1; eal <= Data_bus; ptr <= Data_bus; end
        C2: begin
          if (am == AM_ABS || am == AM_ABX || am == AM_ABY) begin
            eah <= Data_bus; pc <= pc + 16'd1;
          end else if (am == AM_INY) eal <= Data_bus;
        end
        C3: begin
          if (am == AM_INX)      eal <= Data_bus;
          else if (am == AM_INY) eah <= Data_bus;
        end
        C4: if (am == AM_INX) eah <= Data_bus;
        default: ;
      endcase
      if (last) begin
        a <= a_nx; x <= x_nx; y <= y_nx;
        fn <= fn_nx; fv <= fv_nx; fz <= fz_nx; fc <= fc_nx;
      end
    end
  end

  assign IR_dbg    = ir;
  assign AC_dbg    = a;
  assign X_dbg     = x;
  assign Y_dbg     = y;
  assign P_dbg     = {fn, fv, 1'b1, 3'b000, fz, fc};
  assign PC_dbg    = pc;
  assign cycle_dbg = cyc;

endmodule

// File: tb/tb_nes6502_core.sv
// Bench for nes6502_core: directed programs plus random instruction streams,
// checked per cycle and per instruction against an instruction-level model.
module tb_nes6502_core;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [7:0]  Data_bus;
  logic [15:0] Addr_bus;
  logic [7:0]  IR_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg;
  logic [15:0] PC_dbg;
  logic [2:0]  cycle_dbg;

  logic [7:0]  mem [65536];
  assign Data_bus = mem[Addr_bus];

  nes6502_core #(.RESET_PC(16'h0000)) dut (
    .clk_ph1(clk_ph1), .rst(rst), .Data_bus(Data_bus), .Addr_bus(Addr_bus),
    .IR_dbg(IR_dbg), .AC_dbg(AC_dbg), .X_dbg(X_dbg), .Y_dbg(Y_dbg), .P_dbg(P_dbg),
    .PC_dbg(PC_dbg), .cycle_dbg(cycle_dbg)
  );

  always #5 clk_ph1 = ~clk_ph1;

  typedef enum {MD_IMP, MD_IMM, MD_ZP, MD_ZPX, MD_ABS, MD_ABX, MD_ABY, MD_INX, MD_INY} md_t;

  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] m_pc, wp;
  logic [7:0]  m_a, m_x, m_y, m_ir;
  logic        m_n, m_v, m_z, m_c;
  logic [15:0] exp_q [$];
  logic [15:0] obs_addr [8];
  int          obs_len;
  logic [7:0]  op_tab [43];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_p();
    return {m_n, m_v, 1'b1, 3'b000, m_z, m_c};
  endfunction

  function automatic md_t mode_of(input logic [7:0] o);
    case (o)
      8'h69, 8'hE9, 8'hC9, 8'hE0, 8'hC0, 8'hA9, 8'hA2, 8'hA0: return MD_IMM;
      8'h65, 8'hE5, 8'hC5, 8'hE4, 8'hC4:                      return MD_ZP;
      8'h75, 8'hF5, 8'hD5:                                    return MD_ZPX;
      8'h6D, 8'hED, 8'hCD, 8'hEC, 8'hCC:                      return MD_ABS;
      8'h7D, 8'hFD, 8'hDD:                                    return MD_ABX;
      8'h79, 8'hF9, 8'hD9:                                    return MD_ABY;
      8'h61, 8'hE1, 8'hC1:                                    return MD_INX;
      8'h71, 8'hF1, 8'hD1:                                    return MD_INY;
      default:                                                return MD_IMP;
    endcase
  endfunction

  task automatic set_nz(input logic [7:0] r);
    m_n = r[7];
    m_z = (r == 8'h00);
  endtask

  // Binary add/subtract judged by integer range: unsigned for C, signed for V.
  task automatic m_arith(input logic [7:0] m, input bit sub);
    int r, sr, cin;
    cin = int'(m_c);
    if (!sub) begin
      r  = int'(m_a) + int'(m) + cin;
      sr = int'($signed(m_a)) + int'($signed(m)) + cin;
      m_c = (r > 255);
    end else begin
      r  = int'(m_a) - int'(m) - (1 - cin);
      sr = int'($signed(m_a)) - int'($signed(m)) - (1 - cin);
      m_c = (r >= 0);
    end
    m_v = (sr > 127) || (sr < -128);
    m_a = r[7:0];
    set_nz(m_a);
  endtask

  task automatic m_cmp(input logic [7:0] r, input logic [7:0] m);
    logic [7:0] d;
    d = r - m;
    m_c = (r >= m);
    m_z = (r == m);
    m_n = d[7];
  endtask

  task automatic model_step();
    logic [7:0]  opc, lo, hi, p2, p3, m;
    logic [15:0] ea, base;
    exp_q.delete();
    ea = 16'h0000;
    opc = mem[m_pc];
    exp_q.push_back(m_pc);
    m_pc = m_pc + 16'd1;
    m_ir = opc;
    case (mode_of(opc))
      MD_IMP: exp_q.push_back(m_pc);
      MD_IMM: begin ea = m_pc; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1; end
      MD_ZP: begin
        lo = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        ea = {8'h00, lo}; exp_q.push_back(ea);
      end
      MD_ZPX: begin
        lo = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        exp_q.push_back({8'h00, lo});
        p2 = lo + m_x; ea = {8'h00, p2}; exp_q.push_back(ea);
      end
      MD_ABS, MD_ABX, MD_ABY: begin
        lo = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        hi = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        base = {hi, lo};
        if (mode_of(opc) == MD_ABX)      ea = base + {8'h00, m_x};
        else if (mode_of(opc) == MD_ABY) ea = base + {8'h00, m_y};
        else                             ea = base;
        if (ea[15:8] != hi) exp_q.push_back({hi, ea[7:0]});
        exp_q.push_back(ea);
      end
      MD_INX: begin
        lo = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        exp_q.push_back({8'h00, lo});
        p2 = lo + m_x; p3 = p2 + 8'd1;
        exp_q.push_back({8'h00, p2});
        exp_q.push_back({8'h00, p3});
        ea = {mem[{8'h00, p3}], mem[{8'h00, p2}]};
        exp_q.push_back(ea);
      end
      MD_INY: begin
        lo = mem[m_pc]; exp_q.push_back(m_pc); m_pc = m_pc + 16'd1;
        p3 = lo + 8'd1;
        exp_q.push_back({8'h00, lo});
        exp_q.push_back({8'h00, p3});
        base = {mem[{8'h00, p3}], mem[{8'h00, lo}]};
        ea = base + {8'h00, m_y};
        if (ea[15:8] != base[15:8]) exp_q.push_back({base[15:8], ea[7:0]});
        exp_q.push_back(ea);
      end
      default: ;
    endcase
    m = mem[ea];
    case (opc)
      8'h69, 8'h65, 8'h75, 8'h6D, 8'h7D, 8'h79, 8'h61, 8'h71: m_arith(m, 1'b0);
      8'hE9, 8'hE5, 8'hF5, 8'hED, 8'hFD, 8'hF9, 8'hE1, 8'hF1: m_arith(m, 1'b1);
      8'hC9, 8'hC5, 8'hD5, 8'hCD, 8'hDD, 8'hD9, 8'hC1, 8'hD1: m_cmp(m_a, m);
      8'hE0, 8'hE4, 8'hEC: m_cmp(m_x, m);
      8'hC0, 8'hC4, 8'hCC: m_cmp(m_y, m);
      8'hA9: begin m_a = m; set_nz(m_a); end
      8'hA2: begin m_x = m; set_nz(m_x); end
      8'hA0: begin m_y = m; set_nz(m_y); end
      8'h38: m_c = 1'b1;
      8'h18: m_c = 1'b0;
      8'hE8: begin m_x = m_x + 8'd1; set_nz(m_x); end
      8'hC8: begin m_y = m_y + 8'd1; set_nz(m_y); end
      8'hCA: begin m_x = m_x - 8'd1; set_nz(m_x); end
      8'h88: begin m_y = m_y - 8'd1; set_nz(m_y); end
      8'hAA: begin m_x = m_a; set_nz(m_x); end
      8'h8A: begin m_a = m_x; set_nz(m_a); end
      8'hA8: begin m_y = m_a; set_nz(m_y); end
      8'h98: begin m_a = m_y; set_nz(m_a); end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_a = '0; m_x = '0; m_y = '0; m_ir = '0;
    m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // Entered and left at a falling edge while the DUT is in cycle 0.
  task automatic run_instr();
    model_step();
    obs_len = 0;
    for (int k = 0; k < 8; k++) begin
      obs_addr[k] = Addr_bus;
      if (k < exp_q.size()) check("addr", 32'(Addr_bus), 32'(exp_q[k]));
      check("cycle", 32'(cycle_dbg), 32'(k));
      @(posedge clk_ph1);
      @(negedge clk_ph1);
      obs_len = k + 1;
      if (cycle_dbg == 3'd0) break;
    end
    check("len", 32'(obs_len), 32'(exp_q.size()));
    check("a", 32'(AC_dbg), 32'(m_a));
    check("x", 32'(X_dbg), 32'(m_x));
    check("y", 32'(Y_dbg), 32'(m_y));
    check("p", 32'(P_dbg), 32'(m_p()));
    check("pc", 32'(PC_dbg), 32'(m_pc));
    check("ir", 32'(IR_dbg), 32'(m_ir));
  endtask

  task automatic put(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 16'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] opc;
    op_tab = '{8'h69, 8'h65, 8'h75, 8'h6D, 8'h7D, 8'h79, 8'h61, 8'h71,
               8'hE9, 8'hE5, 8'hF5, 8'hED, 8'hFD, 8'hF9, 8'hE1, 8'hF1,
               8'hC9, 8'hC5, 8'hD5, 8'hCD, 8'hDD, 8'hD9, 8'hC1, 8'hD1,
               8'hE0, 8'hE4, 8'hEC, 8'hC0, 8'hC4, 8'hCC, 8'hA9, 8'hA2, 8'hA0,
               8'h38, 8'h18, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_reset();
    wp = 16'h0000;
    put(8'hA9); put(8'h00); put(8'hA2); put(8'h0A); put(8'hA0); put(8'h10);
    put(8'h8A); put(8'h18); put(8'h69); put(8'h10);

    rst = 1'b1;
    @(negedge clk_ph1);
    check("rst_addr", 32'(Addr_bus), 32'h0000);
    @(negedge clk_ph1);
    rst = 1'b0;
    check("rst_pc", 32'(PC_dbg), 32'h0000);
    check("rst_a", 32'(AC_dbg), 32'h00);
    check("rst_x", 32'(X_dbg), 32'h00);
    check("rst_y", 32'(Y_dbg), 32'h00);
    check("rst_ir", 32'(IR_dbg), 32'h00);
    check("rst_p", 32'(P_dbg), 32'h20);
    check("rst_cycle", 32'(cycle_dbg), 32'h0);

    run_instr(); check("tp_lda_a", 32'(AC_dbg), 32'h00); check("tp_lda_p", 32'(P_dbg), 32'h22);
    run_instr(); check("tp_ldx", 32'(X_dbg), 32'h0A);
    run_instr(); check("tp_ldy", 32'(Y_dbg), 32'h10);
    run_instr(); check("tp_txa", 32'(AC_dbg), 32'h0A);
    run_instr();
    run_instr(); check("tp_adc_a", 32'(AC_dbg), 32'h1A); check("tp_adc_p", 32'(P_dbg), 32'h20);
    check("tp_pc", 32'(PC_dbg), 32'h000A);

    put(8'hA9); put(8'h7F); put(8'h18); put(8'h69); put(8'h01);
    repeat (3) run_instr();
    check("ovf_a", 32'(AC_dbg), 32'h80); check("ovf_p", 32'(P_dbg), 32'hE0);
    put(8'hA9); put(8'hFF); put(8'h38); put(8'h69); put(8'h00);
    repeat (3) run_instr();
    check("carry_a", 32'(AC_dbg), 32'h00); check("carry_p", 32'(P_dbg), 32'h23);
    put(8'h38); put(8'hA9); put(8'h05); put(8'hE9); put(8'h06);
    repeat (3) run_instr();
    check("sbc_a", 32'(AC_dbg), 32'hFF); check("sbc_p", 32'(P_dbg), 32'hA0);
    put(8'hA9); put(8'h10); put(8'hC9); put(8'h10);
    repeat (2) run_instr();
    check("cmp_a", 32'(AC_dbg), 32'h10); check("cmp_p", 32'(P_dbg), 32'h23);
    put(8'hA2); put(8'hFF); put(8'hE8);
    repeat (2) run_instr();
    check("inx_x", 32'(X_dbg), 32'h00); check("inx_p", 32'(P_dbg), 32'h23);
    put(8'hA0); put(8'h00); put(8'h88);
    repeat (2) run_instr();
    check("dey_y", 32'(Y_dbg), 32'hFF); check("dey_p", 32'(P_dbg), 32'hA1);

    put(8'hA2); put(8'h0F); put(8'h7D); put(8'hF0); put(8'h12);
    repeat (2) run_instr();
    check("absx_nc_len", 32'(obs_len), 32'd4);
    check("absx_nc_addr", 32'(obs_addr[3]), 32'h12FF);
    put(8'hA2); put(8'h10); put(8'h7D); put(8'hF0); put(8'h12);
    repeat (2) run_instr();
    check("absx_c_len", 32'(obs_len), 32'd5);
    check("absx_c_dummy", 32'(obs_addr[3]), 32'h1200);
    check("absx_c_addr", 32'(obs_addr[4]), 32'h1300);

    put(8'hA0); put(8'h05); put(8'h71); put(8'h40);
    run_instr();
    repeat (3) begin @(posedge clk_ph1); @(negedge clk_ph1); end
    check("indy_c3", 32'(cycle_dbg), 32'd3);
    rst = 1'b1;
    @(posedge clk_ph1);
    @(negedge clk_ph1);
    rst = 1'b0;
    check("mid_rst_pc", 32'(PC_dbg), 32'h0000);
    check("mid_rst_cycle", 32'(cycle_dbg), 32'd0);
    check("mid_rst_a", 32'(AC_dbg), 32'h00);
    check("mid_rst_x", 32'(X_dbg), 32'h00);
    check("mid_rst_y", 32'(Y_dbg), 32'h00);
    check("mid_rst_p", 32'(P_dbg), 32'h20);
    check("mid_rst_addr", 32'(Addr_bus), 32'h0000);
    model_reset();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) opc = op_tab[$urandom_range(0, 42)];
      else                          opc = 8'($urandom);
      mem[m_pc] = opc;
      mem[m_pc + 16'd1] = 8'($urandom);
      mem[m_pc + 16'd2] = 8'($urandom);
      run_instr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
